// File: rtl/req_chan_arb4.sv
// rtl/req_chan_arb4.sv - 4-requester round-robin arbiter with registered one-entry output slice; option REQ_ARB_IDTAG_EN
module req_chan_arb4 #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int ATOP_W = 6,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        m_valid,
  output logic [NREQ-1:0]        m_ready,
  input  logic [NREQ*ID_W-1:0]   m_id,
  input  logic [NREQ*ADDR_W-1:0] m_addr,
  input  logic [NREQ*ATOP_W-1:0] m_atop,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [ID_W-1:0]        a_id,
  output logic [ADDR_W-1:0]      a_addr,
  output logic [ATOP_W-1:0]      a_atop,
  output logic [1:0]             a_src
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slice_state_e;

  slice_state_e    state_q, state_d;
  logic [1:0]      rr_ptr;
  logic [1:0]      win;
  logic            found;
  logic            load;
  logic            grant;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] id_d;

  // First valid requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!found && m_valid[rr_ptr + 2'(k)]) begin
        found = 1'b1;
        win   = rr_ptr + 2'(k);
      end
    end
  end

  assign load   = (state_q == S_EMPTY) | a_ready;
  assign grant  = load & found & rst_n;
  assign win_id = m_id[win*ID_W +: ID_W];

`ifdef REQ_ARB_IDTAG_EN
  // Upper id bits are replaced by the source index for response routing.
  assign id_d = {win, win_id[ID_W-3:0]};
`else
  assign id_d = win_id;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = found ? S_FULL : S_EMPTY;
    end
  end

  always_comb begin
    a_valid = (state_q == S_FULL);
    m_ready = grant ? (NREQ'(1) << win) : '0;
  end

  // Payload and pointer move only on a requester handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_id   <= '0;
      a_addr <= '0;
      a_atop <= '0;
      a_src  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      a_id   <= id_d;
      a_addr <= m_addr[win*ADDR_W +: ADDR_W];
      a_atop <= m_atop[win*ATOP_W +: ATOP_W];
      a_src  <= win;
      rr_ptr <= win + 2'd1;
    end
  end

endmodule

// File: tb/tb_req_chan_arb4.sv
// tb/tb_req_chan_arb4.sv - self-checking bench for req_chan_arb4
module tb_req_chan_arb4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   m_valid;
  logic [3:0]   m_ready;
  logic [15:0]  m_id;
  logic [127:0] m_addr;
  logic [23:0]  m_atop;
  logic         a_valid;
  logic         a_ready;
  logic [3:0]   a_id;
  logic [31:0]  a_addr;
  logic [5:0]   a_atop;
  logic [1:0]   a_src;

  int checks   = 0;
  int failures = 0;

  req_chan_arb4 #(.ID_W(4), .ADDR_W(32), .ATOP_W(6), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_id(m_id), .m_addr(m_addr), .m_atop(m_atop),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_id(a_id), .a_addr(a_addr), .a_atop(a_atop), .a_src(a_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue-of-one slice plus an integer round-robin pointer.
  logic       q_valid;
  logic [3:0] q_id;
  logic [31:0] q_addr;
  logic [5:0] q_atop;
  logic [1:0] q_src;
  int         q_ptr;
  int         mw;
  logic [3:0] exp_mr;

  function automatic int model_winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_id(input int w);
    logic [3:0] f;
    f = m_id[w*4 +: 4];
`ifdef REQ_ARB_IDTAG_EN
    f[3:2] = w[1:0];
`endif
    return f;
  endfunction

  assign mw     = model_winner(m_valid, q_ptr);
  assign exp_mr = (rst_n && (!q_valid || a_ready) && mw >= 0) ? 4'(1 << mw) : 4'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_id    <= '0;
      q_addr  <= '0;
      q_atop  <= '0;
      q_src   <= '0;
      q_ptr   <= 0;
    end else if (!q_valid || a_ready) begin
      if (mw >= 0) begin
        q_valid <= 1'b1;
        q_id    <= model_id(mw);
        q_addr  <= m_addr[mw*32 +: 32];
        q_atop  <= m_atop[mw*6 +: 6];
        q_src   <= 2'(mw);
        q_ptr   <= (mw + 1) % 4;
      end else begin
        q_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready", 64'(m_ready), 64'(exp_mr));
    chk("a_valid", 64'(a_valid), 64'(q_valid));
    chk("a_id",    64'(a_id),    64'(q_id));
    chk("a_addr",  64'(a_addr),  64'(q_addr));
    chk("a_atop",  64'(a_atop),  64'(q_atop));
    chk("a_src",   64'(a_src),   64'(q_src));
  end

  int         exp_src [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp_rdy [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    m_valid = 4'b0;
    a_ready = 1'b1;
    m_id    = {4'hC, 4'hA, 4'h5, 4'h3};
    m_addr  = {32'h3000_0300, 32'h2000_0200, 32'h1000_0040, 32'h0000_0100};
    m_atop  = {6'h14, 6'h13, 6'h12, 6'h11};
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with no requests
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_a_valid", 64'(a_valid), 64'd0);
      chk("rst_m_ready", 64'(m_ready), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("idle_a_valid", 64'(a_valid), 64'd0);
      chk("idle_m_ready", 64'(m_ready), 64'd0);
    end

    // All four requesting: rotation 0,1,2,3,0
    m_valid = 4'b1111;
    #1 chk("rr_first_ready", 64'(m_ready), 64'b0001);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk); #1;
      chk("rr_a_src",   64'(a_src),   64'(exp_src[n]));
      chk("rr_a_valid", 64'(a_valid), 64'd1);
      chk("rr_m_ready", 64'(m_ready), 64'(exp_rdy[n]));
    end
    m_valid = 4'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("drain_a_valid", 64'(a_valid), 64'd0);
    chk("drain_a_src",   64'(a_src),   64'd0);

    // Requester 1 alone
    m_valid = 4'b0010;
    #1 chk("req1_m_ready", 64'(m_ready), 64'b0010);
    @(posedge clk); #1 m_valid = 4'b0;
    @(negedge clk); #1;
    chk("req1_a_valid", 64'(a_valid), 64'd1);
    chk("req1_a_addr",  64'(a_addr),  64'h1000_0040);
    chk("req1_a_src",   64'(a_src),   64'd1);
    chk("req1_a_id",    64'(a_id),    64'h5);

    // Backpressure for 5 cycles, then drain+reload
    a_ready = 1'b0;
    m_valid = 4'b1001;
    repeat (5) begin
      @(posedge clk); @(negedge clk); #1;
      chk("bp_m_ready", 64'(m_ready), 64'd0);
      chk("bp_a_valid", 64'(a_valid), 64'd1);
      chk("bp_a_src",   64'(a_src),   64'd1);
      chk("bp_a_addr",  64'(a_addr),  64'h1000_0040);
    end
    a_ready = 1'b1;
    #1 chk("reload_m_ready", 64'(m_ready), 64'b1000);
    @(posedge clk); #1 m_valid = 4'b0100;
    @(negedge clk); #1;
    chk("reload_a_valid", 64'(a_valid), 64'd1);
    chk("reload_a_src",   64'(a_src),   64'd3);
    chk("reload_a_addr",  64'(a_addr),  64'h3000_0300);
    chk("ptr0_m_ready",   64'(m_ready), 64'b0100);

    // Pointer wrap: grant 2 leaves rr_ptr=3
    @(posedge clk); #1 m_valid = 4'b0001;
    @(negedge clk); #1;
    chk("wrap_a_src2",   64'(a_src),   64'd2);
    chk("wrap_m_ready0", 64'(m_ready), 64'b0001);
    @(posedge clk); #1 m_valid = 4'b1001;
    @(negedge clk); #1;
    chk("wrap_a_src0",   64'(a_src),   64'd0);
    chk("wrap_m_ready3", 64'(m_ready), 64'b1000);
    @(posedge clk); #1 m_valid = 4'b0100;
    @(negedge clk); #1;
    chk("wrap_a_src3",   64'(a_src),   64'd3);
    chk("full_a_valid",  64'(a_valid), 64'd1);

    // Asynchronous reset while full
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 64'(a_valid), 64'd0);
    chk("arst_m_ready", 64'(m_ready), 64'd0);
    chk("arst_a_src",   64'(a_src),   64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("post_rst_m_ready", 64'(m_ready), 64'b0100);
    @(posedge clk); #1 m_valid = 4'b0;
    @(negedge clk); #1;
    chk("post_rst_a_src",   64'(a_src),   64'd2);
    chk("post_rst_a_valid", 64'(a_valid), 64'd1);
    chk("post_rst_a_addr",  64'(a_addr),  64'h2000_0200);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
